// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: port IDs, arbiter states, read-return record.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package dmem_pkg;

    // Requesting master. The value doubles as the "last granted" marker.
    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_AUX = 1'b1
    } port_e;

    // Arbiter mode: plain round-robin, or an aux burst in progress.
    typedef enum logic {
        ARB_RR        = 1'b0,
        ARB_AUX_BURST = 1'b1
    } arb_state_e;

    // One in-flight read, captured at grant and consumed when the RAM answers.
    typedef struct packed {
        logic       vld;      // a read was granted last cycle
        port_e      port;     // which master gets the data
        logic [1:0] lane;     // byte lane for byte reads
        logic       byte_rd;  // extract one byte instead of the whole word
        logic       oor;      // address was out of range: return zero
    } rret_t;

    // One-hot write strobe for a single byte lane.
    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Per-port byte-lane helper: write strobes, write-data replication, read-byte extraction.
// Latency: purely combinational.
// Backpressure: none; the arbiter decides whether the strobes are used.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  adr_lo,   // byte offset of the request
    input  logic        byte_en,  // request is a byte access
    input  logic [31:0] wd,       // request write data
    input  logic [1:0]  rd_lane,  // lane captured when the pending read was granted
    input  logic        rd_byte,  // pending read is a byte read
    input  logic [31:0] mem_rd,   // RAM read data
    output logic [3:0]  wr_be,    // lane strobes if this write is granted
    output logic [31:0] wr_dat,   // write data presented to the RAM
    output logic [31:0] rd_dat    // read data after byte extraction
);

    // Byte writes hit one lane with the low byte copied everywhere; word writes
    // ignore the low address bits, so misaligned word writes land on the whole word.
    always_comb begin
        wr_be  = 4'b1111;
        wr_dat = wd;
        if (byte_en) begin
            wr_be  = lane_be(adr_lo);
            wr_dat = {4{wd[7:0]}};
        end
    end

    // Byte reads are zero-extended from the lane recorded at grant time.
    always_comb begin
        rd_dat = mem_rd;
        if (rd_byte) begin
            rd_dat = {24'h0, mem_rd[8*rd_lane +: 8]};
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one registered-read data RAM between the CPU and an aux master with round-robin and bounded aux bursts.
// Latency: grant and write strobes in the request cycle; read data one cycle after grant.
// Backpressure: a requester not granted keeps its request up (cpu_stall flags the CPU case); no queuing.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     cpu_req,
    input  logic [31:0]              cpu_adr,
    input  logic [31:0]              cpu_wd,
    input  logic                     cpu_we,
    input  logic                     cpu_byte,

    input  logic                     aux_req,
    input  logic [31:0]              aux_adr,
    input  logic [31:0]              aux_wd,
    input  logic                     aux_we,
    input  logic                     aux_byte,
    input  logic                     aux_lock,

    output logic                     cpu_gnt,
    output logic                     aux_gnt,
    output logic                     cpu_stall,
    output logic                     cpu_rvalid,
    output logic                     aux_rvalid,
    output logic [31:0]              cpu_rdata,
    output logic [31:0]              aux_rdata,
    output logic                     err,

    output logic [$clog2(DEPTH)-1:0] mem_adr,
    output logic [31:0]              mem_wd,
    output logic [3:0]               mem_be,
    input  logic [31:0]              mem_rd
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] ADR_LIMIT = 32'(4 * DEPTH);
    localparam logic [3:0]  BURST_MAX = 4'(MAX_BURST);

    // Arbitration state
    arb_state_e state_q, state_d;
    port_e      last_q, last_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       burst_hold;

    // Granted request, muxed from the winning port
    port_e       sel_port;
    logic [31:0] sel_adr;
    logic        sel_we;
    logic        sel_byte;
    logic [3:0]  sel_be;
    logic [31:0] sel_wdat;
    logic        sel_oor;
    logic        any_gnt;

    // Per-port lane helper outputs
    logic [3:0]  cpu_be, aux_be;
    logic [31:0] cpu_wdat, aux_wdat;
    logic [31:0] cpu_rd_raw, aux_rd_raw;

    // Idle-cycle address hold and read-return pipeline
    logic [AW-1:0] adr_hold_q;
    rret_t         rret_q, rret_d;

    dmem_lane u_cpu_lane (
        .adr_lo  (cpu_adr[1:0]),
        .byte_en (cpu_byte),
        .wd      (cpu_wd),
        .rd_lane (rret_q.lane),
        .rd_byte (rret_q.byte_rd),
        .mem_rd  (mem_rd),
        .wr_be   (cpu_be),
        .wr_dat  (cpu_wdat),
        .rd_dat  (cpu_rd_raw)
    );

    dmem_lane u_aux_lane (
        .adr_lo  (aux_adr[1:0]),
        .byte_en (aux_byte),
        .wd      (aux_wd),
        .rd_lane (rret_q.lane),
        .rd_byte (rret_q.byte_rd),
        .mem_rd  (mem_rd),
        .wr_be   (aux_be),
        .wr_dat  (aux_wdat),
        .rd_dat  (aux_rd_raw)
    );

    // Grant: an active burst keeps aux on top until it runs out; otherwise the
    // port that did not win last time takes a contested cycle. Nothing is
    // granted while reset is held.
    always_comb begin
        cpu_gnt    = 1'b0;
        aux_gnt    = 1'b0;
        burst_hold = (state_q == ARB_AUX_BURST) && aux_req && aux_lock &&
                     (burst_cnt_q < BURST_MAX);
        if (!reset) begin
            if (burst_hold) begin
                aux_gnt = 1'b1;
            end else if (cpu_req && aux_req) begin
                if (last_q == PORT_CPU) begin
                    aux_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (aux_req) begin
                aux_gnt = 1'b1;
            end
        end
    end

    // Next state: a locked aux grant starts or extends a burst; anything else
    // (lock or request dropped, budget spent, CPU won) falls back to RR.
    // A locked aux grant right after an exhausted burst starts a fresh one.
    always_comb begin
        state_d     = ARB_RR;
        burst_cnt_d = 4'd0;
        last_d      = last_q;
        if (cpu_gnt) begin
            last_d = PORT_CPU;
        end
        if (aux_gnt) begin
            last_d = PORT_AUX;
        end
        if (aux_gnt && aux_lock) begin
            state_d     = ARB_AUX_BURST;
            burst_cnt_d = burst_hold ? (burst_cnt_q + 4'd1) : 4'd1;
        end
    end

    // Route the winning port's request towards the RAM.
    always_comb begin
        any_gnt  = cpu_gnt | aux_gnt;
        sel_port = aux_gnt ? PORT_AUX : PORT_CPU;
        sel_adr  = cpu_adr;
        sel_we   = cpu_we;
        sel_byte = cpu_byte;
        sel_be   = cpu_be;
        sel_wdat = cpu_wdat;
        if (aux_gnt) begin
            sel_adr  = aux_adr;
            sel_we   = aux_we;
            sel_byte = aux_byte;
            sel_be   = aux_be;
            sel_wdat = aux_wdat;
        end
        sel_oor = (sel_adr >= ADR_LIMIT);
    end

    // RAM side: strobes only for in-range granted writes; the address holds
    // its last granted value when idle so the RAM output stays put.
    always_comb begin
        mem_wd    = sel_wdat;
        mem_be    = (any_gnt && sel_we && !sel_oor) ? sel_be : 4'b0000;
        mem_adr   = any_gnt ? sel_adr[AW+1:2] : adr_hold_q;
        err       = any_gnt && sel_oor;
        cpu_stall = cpu_req & ~cpu_gnt;
    end

    // Capture what the read return next cycle needs to know about this grant.
    always_comb begin
        rret_d         = '0;
        rret_d.vld     = any_gnt && !sel_we;
        rret_d.port    = sel_port;
        rret_d.lane    = sel_adr[1:0];
        rret_d.byte_rd = sel_byte;
        rret_d.oor     = sel_oor;
    end

    // State, held address and read-return registers; reset drops any pending read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_RR;
            last_q      <= PORT_AUX;
            burst_cnt_q <= 4'd0;
            adr_hold_q  <= '0;
            rret_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            rret_q      <= rret_d;
            if (any_gnt) begin
                adr_hold_q <= sel_adr[AW+1:2];
            end
        end
    end

    // Read return: steer RAM data to the port that asked; out-of-range reads
    // and idle cycles yield zero.
    always_comb begin
        cpu_rvalid = rret_q.vld && (rret_q.port == PORT_CPU);
        aux_rvalid = rret_q.vld && (rret_q.port == PORT_AUX);
        cpu_rdata  = (cpu_rvalid && !rret_q.oor) ? cpu_rd_raw : 32'h0;
        aux_rdata  = (aux_rvalid && !rret_q.oor) ? aux_rd_raw : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand sequences for alternation, bursts and reset, then random traffic vs a model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_arbiter;

    localparam int DEPTH     = 64;
    localparam int MAX_BURST = 4;

    logic        clk, reset;
    logic        cpu_req, cpu_we, cpu_byte;
    logic [31:0] cpu_adr, cpu_wd;
    logic        aux_req, aux_we, aux_byte, aux_lock;
    logic [31:0] aux_adr, aux_wd;
    logic        cpu_gnt, aux_gnt, cpu_stall, cpu_rvalid, aux_rvalid, err;
    logic [31:0] cpu_rdata, aux_rdata;
    logic [5:0]  mem_adr;
    logic [31:0] mem_wd, mem_rd;
    logic [3:0]  mem_be;

    dmem_arbiter #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
        .aux_req(aux_req), .aux_adr(aux_adr), .aux_wd(aux_wd), .aux_we(aux_we), .aux_byte(aux_byte),
        .aux_lock(aux_lock),
        .cpu_gnt(cpu_gnt), .aux_gnt(aux_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .aux_rvalid(aux_rvalid),
        .cpu_rdata(cpu_rdata), .aux_rdata(aux_rdata), .err(err),
        .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_be(mem_be), .mem_rd(mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Write-first RAM with registered read, cleared on request.
    logic [31:0] ram [DEPTH];
    logic [31:0] ram_next;
    logic        ram_clr;

    always_comb begin
        ram_next = ram[mem_adr];
        for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) ram_next[8*b +: 8] = mem_wd[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 32'h0;
        end else begin
            ram[mem_adr] <= ram_next;
        end
        mem_rd <= ram_next;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        cpu_req = 0; cpu_adr = 0; cpu_wd = 0; cpu_we = 0; cpu_byte = 0;
        aux_req = 0; aux_adr = 0; aux_wd = 0; aux_we = 0; aux_byte = 0; aux_lock = 0;
    endtask

    task automatic both_read(input logic lock);
        cpu_req = 1; cpu_adr = 32'h0; cpu_we = 0; cpu_byte = 0;
        aux_req = 1; aux_adr = 32'h4; aux_we = 0; aux_byte = 0; aux_lock = lock;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_in();
        reset = 1; ram_clr = 1;
        next_cycle();
        next_cycle();
        ram_clr = 0; reset = 0;
    endtask

    typedef struct {
        logic creq; logic [31:0] cadr; logic cwe; logic cby; logic [31:0] cwd;
        logic areq; logic [31:0] aadr; logic awe; logic aby; logic [31:0] awd; logic alk;
        logic ecg; logic eag; logic [3:0] ebe; logic [5:0] ema; logic [31:0] ewd; logic eer;
        logic ecv; logic eav; logic [31:0] ecd; logic [31:0] ead;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];

    // Reference model state for random traffic
    logic [31:0] ref_mem [DEPTH];
    int          streak;
    bit          last_aux, pv, pport, c_hold, a_hold, gc, ga, hold_aux, oor;
    logic [31:0] pdat, s_adr, s_wd;
    logic        s_we, s_by;
    logic [3:0]  ebe;
    logic [5:0]  held_madr;
    string       pat;

    function automatic logic [31:0] rand_adr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h100 + 32'($urandom_range(0, 255));
        if (r == 1) return $urandom;
        return 32'($urandom_range(0, 4*DEPTH-1));
    endfunction

    initial begin
        //           creq cadr    cwe  cby  cwd            areq aadr    awe  aby  awd            alk   ecg  eag  ebe   ema    ewd            eer   ecv  eav  ecd            ead
        vt[0]  = '{1'b1,32'hC8, 1'b1,1'b0,32'h1,        1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b0,4'hF,6'd50,32'h1,        1'b0, 1'b0,1'b0,32'h0,       32'h0};
        vt[1]  = '{1'b1,32'hC8, 1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b0,4'h0,6'd50,32'h0,        1'b0, 1'b0,1'b0,32'h0,       32'h0};
        vt[2]  = '{1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b0,4'h0,6'd50,32'h0,        1'b0, 1'b1,1'b0,32'h1,       32'h0};
        vt[3]  = '{1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b1,32'h0D, 1'b1,1'b1,32'hAB,       1'b0, 1'b0,1'b1,4'h2,6'd3, 32'hABABABAB, 1'b0, 1'b0,1'b0,32'h0,       32'h0};
        vt[4]  = '{1'b1,32'h0D, 1'b0,1'b1,32'h0,        1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b0,4'h0,6'd3, 32'h0,        1'b0, 1'b0,1'b0,32'h0,       32'h0};
        vt[5]  = '{1'b1,32'h0C, 1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b0,4'h0,6'd3, 32'h0,        1'b0, 1'b1,1'b0,32'hAB,      32'h0};
        vt[6]  = '{1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b0,4'h0,6'd3, 32'h0,        1'b0, 1'b1,1'b0,32'hAB00,    32'h0};
        vt[7]  = '{1'b1,32'h100,1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b0,4'h0,6'd0, 32'h0,        1'b1, 1'b0,1'b0,32'h0,       32'h0};
        vt[8]  = '{1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b0,4'h0,6'd0, 32'h0,        1'b0, 1'b1,1'b0,32'h0,       32'h0};
        vt[9]  = '{1'b1,32'hC8, 1'b0,1'b0,32'h0,        1'b1,32'h0C, 1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b1,4'h0,6'd3, 32'h0,        1'b0, 1'b0,1'b0,32'h0,       32'h0};
        vt[10] = '{1'b1,32'hC8, 1'b0,1'b0,32'h0,        1'b1,32'h0C, 1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b0,4'h0,6'd50,32'h0,        1'b0, 1'b0,1'b1,32'h0,       32'hAB00};
        vt[11] = '{1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b0,4'h0,6'd50,32'h0,        1'b0, 1'b1,1'b0,32'h1,       32'h0};
        vt[12] = '{1'b1,32'h13, 1'b1,1'b0,32'h12345678, 1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b0,4'hF,6'd4, 32'h12345678, 1'b0, 1'b0,1'b0,32'h0,       32'h0};
        vt[13] = '{1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b1,32'h10, 1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b1,4'h0,6'd4, 32'h0,        1'b0, 1'b0,1'b0,32'h0,       32'h0};
        vt[14] = '{1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b0,4'h0,6'd4, 32'h0,        1'b0, 1'b0,1'b1,32'h0,       32'h12345678};
        vt[15] = '{1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b1,32'h12, 1'b0,1'b1,32'h0,        1'b0, 1'b0,1'b1,4'h0,6'd4, 32'h0,        1'b0, 1'b0,1'b0,32'h0,       32'h0};
        vt[16] = '{1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b0,4'h0,6'd4, 32'h0,        1'b0, 1'b0,1'b1,32'h0,       32'h34};
        vt[17] = '{1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b1,32'h104,1'b1,1'b0,32'hFFFFFFFF, 1'b0, 1'b0,1'b1,4'h0,6'd1, 32'h0,        1'b1, 1'b0,1'b0,32'h0,       32'h0};
        vt[18] = '{1'b1,32'h04, 1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b0,4'h0,6'd1, 32'h0,        1'b0, 1'b0,1'b0,32'h0,       32'h0};
        vt[19] = '{1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b0,4'h0,6'd1, 32'h0,        1'b0, 1'b1,1'b0,32'h0,       32'h0};

        // Reset state
        idle_in();
        reset = 1; ram_clr = 1;
        next_cycle();
        next_cycle();
        check("rst cpu_gnt", 32'(cpu_gnt), 32'h0);
        check("rst aux_gnt", 32'(aux_gnt), 32'h0);
        check("rst cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check("rst aux_rvalid", 32'(aux_rvalid), 32'h0);
        check("rst err", 32'(err), 32'h0);
        check("rst cpu_rdata", cpu_rdata, 32'h0);
        check("rst aux_rdata", aux_rdata, 32'h0);
        check("rst mem_be", 32'(mem_be), 32'h0);
        check("rst mem_adr", 32'(mem_adr), 32'h0);
        ram_clr = 0; reset = 0;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            cpu_req = vt[i].creq; cpu_adr = vt[i].cadr; cpu_we = vt[i].cwe; cpu_byte = vt[i].cby; cpu_wd = vt[i].cwd;
            aux_req = vt[i].areq; aux_adr = vt[i].aadr; aux_we = vt[i].awe; aux_byte = vt[i].aby; aux_wd = vt[i].awd;
            aux_lock = vt[i].alk;
            #4;
            check($sformatf("vec%0d cpu_gnt", i), 32'(cpu_gnt), 32'(vt[i].ecg));
            check($sformatf("vec%0d aux_gnt", i), 32'(aux_gnt), 32'(vt[i].eag));
            check($sformatf("vec%0d cpu_stall", i), 32'(cpu_stall), 32'(vt[i].creq & ~vt[i].ecg));
            check($sformatf("vec%0d mem_be", i), 32'(mem_be), 32'(vt[i].ebe));
            check($sformatf("vec%0d mem_adr", i), 32'(mem_adr), 32'(vt[i].ema));
            if (vt[i].ebe != 4'h0) check($sformatf("vec%0d mem_wd", i), mem_wd, vt[i].ewd);
            check($sformatf("vec%0d err", i), 32'(err), 32'(vt[i].eer));
            check($sformatf("vec%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vt[i].ecv));
            check($sformatf("vec%0d aux_rvalid", i), 32'(aux_rvalid), 32'(vt[i].eav));
            check($sformatf("vec%0d cpu_rdata", i), cpu_rdata, vt[i].ecd);
            check($sformatf("vec%0d aux_rdata", i), aux_rdata, vt[i].ead);
            next_cycle();
        end
        idle_in();

        // Alternation after reset: CPU first, then strict ping-pong
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            both_read(1'b0);
            #4;
            check($sformatf("alt%0d cpu_gnt", k), 32'(cpu_gnt), 32'(k % 2 == 0));
            check($sformatf("alt%0d aux_gnt", k), 32'(aux_gnt), 32'(k % 2 == 1));
            check($sformatf("alt%0d cpu_stall", k), 32'(cpu_stall), 32'(k % 2 == 1));
            if (k > 0) check($sformatf("alt%0d cpu_rvalid", k), 32'(cpu_rvalid), 32'((k - 1) % 2 == 0));
            if (k > 0) check($sformatf("alt%0d aux_rvalid", k), 32'(aux_rvalid), 32'((k - 1) % 2 == 1));
            next_cycle();
        end

        // Locked aux bursts of MAX_BURST, one CPU slot between them
        pat = "CAAAACAAAAC";
        for (int k = 0; k < pat.len(); k++) begin
            both_read(1'b1);
            #4;
            check($sformatf("burst%0d cpu_gnt", k), 32'(cpu_gnt), 32'(pat[k] == "C"));
            check($sformatf("burst%0d aux_gnt", k), 32'(aux_gnt), 32'(pat[k] == "A"));
            next_cycle();
        end

        // Reset in the cycle after a granted aux read, inside a burst
        for (int k = 0; k < 2; k++) begin
            both_read(1'b1);
            #4;
            check($sformatf("preset%0d aux_gnt", k), 32'(aux_gnt), 32'h1);
            next_cycle();
        end
        idle_in();
        reset = 1;
        #4;
        check("midrst aux_rvalid", 32'(aux_rvalid), 32'h0);
        check("midrst cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check("midrst rdata", cpu_rdata | aux_rdata, 32'h0);
        check("midrst gnt/stall/err", 32'({cpu_gnt, aux_gnt, cpu_stall, err}), 32'h0);
        check("midrst mem_be", 32'(mem_be), 32'h0);
        check("midrst mem_adr", 32'(mem_adr), 32'h0);
        next_cycle();
        reset = 0;
        both_read(1'b1);
        #4;
        check("postrst cpu_gnt", 32'(cpu_gnt), 32'h1);
        check("postrst aux_gnt", 32'(aux_gnt), 32'h0);
        check("postrst aux_rvalid", 32'(aux_rvalid), 32'h0);
        next_cycle();
        idle_in();

        // Random traffic against the reference model
        apply_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        streak = 0; last_aux = 1; pv = 0; pport = 0; pdat = 0; held_madr = 0;
        c_hold = 0; a_hold = 0;
        for (int n = 0; n < 600; n++) begin
            if (!c_hold) begin
                cpu_req = ($urandom_range(0, 2) != 0); cpu_adr = rand_adr();
                cpu_we = 1'($urandom_range(0, 1)); cpu_byte = 1'($urandom_range(0, 1)); cpu_wd = $urandom;
            end
            if (!a_hold) begin
                aux_req = ($urandom_range(0, 2) != 0); aux_adr = rand_adr();
                aux_we = 1'($urandom_range(0, 1)); aux_byte = 1'($urandom_range(0, 1)); aux_wd = $urandom;
            end
            aux_lock = ($urandom_range(0, 3) != 0);
            #4;
            // A locked aux run keeps priority until it has taken MAX_BURST slots in a row.
            hold_aux = aux_req && aux_lock && streak > 0 && (streak % MAX_BURST) != 0;
            if (hold_aux) begin gc = 0; ga = 1; end
            else if (cpu_req && aux_req) begin ga = !last_aux; gc = last_aux; end
            else begin gc = cpu_req; ga = aux_req; end
            s_adr = ga ? aux_adr : cpu_adr;
            s_we  = ga ? aux_we  : cpu_we;
            s_by  = ga ? aux_byte : cpu_byte;
            s_wd  = ga ? aux_wd  : cpu_wd;
            oor = (gc || ga) && (s_adr >= 32'(4 * DEPTH));
            ebe = 4'h0;
            if ((gc || ga) && s_we && !oor) ebe = s_by ? (4'b0001 << s_adr[1:0]) : 4'hF;
            if (gc || ga) held_madr = s_adr[7:2];
            check($sformatf("rnd%0d cpu_gnt", n), 32'(cpu_gnt), 32'(gc));
            check($sformatf("rnd%0d aux_gnt", n), 32'(aux_gnt), 32'(ga));
            check($sformatf("rnd%0d cpu_stall", n), 32'(cpu_stall), 32'(cpu_req && !gc));
            check($sformatf("rnd%0d mem_be", n), 32'(mem_be), 32'(ebe));
            check($sformatf("rnd%0d mem_adr", n), 32'(mem_adr), 32'(held_madr));
            check($sformatf("rnd%0d err", n), 32'(err), 32'(oor));
            if (ebe != 4'h0) check($sformatf("rnd%0d mem_wd", n), mem_wd, s_by ? {4{s_wd[7:0]}} : s_wd);
            check($sformatf("rnd%0d cpu_rvalid", n), 32'(cpu_rvalid), 32'(pv && !pport));
            check($sformatf("rnd%0d aux_rvalid", n), 32'(aux_rvalid), 32'(pv && pport));
            check($sformatf("rnd%0d cpu_rdata", n), cpu_rdata, (pv && !pport) ? pdat : 32'h0);
            check($sformatf("rnd%0d aux_rdata", n), aux_rdata, (pv && pport) ? pdat : 32'h0);
            // Advance the model by one cycle
            if (ebe != 4'h0) begin
                if (s_by) ref_mem[s_adr[7:2]][8*s_adr[1:0] +: 8] = s_wd[7:0];
                else      ref_mem[s_adr[7:2]] = s_wd;
            end
            pv = (gc || ga) && !s_we;
            pport = ga;
            if (oor)       pdat = 32'h0;
            else if (s_by) pdat = {24'h0, ref_mem[s_adr[7:2]][8*s_adr[1:0] +: 8]};
            else           pdat = ref_mem[s_adr[7:2]];
            streak = (ga && aux_lock) ? streak + 1 : 0;
            if (ga) last_aux = 1;
            else if (gc) last_aux = 0;
            c_hold = cpu_req && !gc;
            a_hold = aux_req && !ga;
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
